// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified instruction/data RAM port arbiter:
//   default address/data widths, the NOP instruction returned to IF when no
//   fetch data is valid, and the encoding of the read-owner register.
package mem_port_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  // Instruction word fed to IF/ID whenever no fetch data is returning.
  localparam logic [15:0] EXE_NOP_OP = 16'h0000;

  // Which requester owns the RAM read data arriving next cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_IF   = 2'd1,
    RD_MEM  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
//   Combinational priority between the fetch and data requesters.
//   MEM normally wins a conflict; once IF has been denied STARVE_LIM
//   consecutive cycles IF wins instead.
// Ports:
//   if_req, mem_req  in   requests
//   starve_cnt       in   consecutive denied-fetch count (from the top)
//   if_gnt, mem_gnt  out  one-hot (or zero) grants
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          mem_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          if_gnt,
  output logic          mem_gnt
);

  logic starved;

  always_comb begin
    starved = (starve_cnt == SW'(STARVE_LIM));
    if_gnt  = if_req && (!mem_req || starved);
    mem_gnt = mem_req && !(if_req && starved);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified RAM between instruction fetch (IF) and
//   load/store (MEM), one access per cycle. Issues the RAM command for the
//   granted requester, steers read data (one cycle later) back to whoever
//   issued the read, and raises per-stage stall requests.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        fetch request / accept
//   if_rvalid/if_rdata              fetch return (NOP when not valid)
//   mem_req/we/addr/wdata -> gnt    data request / accept
//   mem_rvalid/mem_rdata            load return (0 when not valid)
//   stall_if, stall_mem             request && !grant
//   ram_ce/we/addr/wdata, ram_rdata RAM command and read data
//   conflict_cnt                    cycles with both requests; only counts
//                                   when MEM_ARB_STAT_EN is defined, else 0
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIM)) ? v : v + 1'b1;
  endfunction

  logic          if_gnt_raw;
  logic          mem_gnt_raw;
  logic [SW-1:0] starve_q, starve_d;
  rd_owner_e     rd_owner_q, rd_owner_d;

  mem_arb_grant #(
    .STARVE_LIM (STARVE_LIM),
    .SW         (SW)
  ) u_grant (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .starve_cnt (starve_q),
    .if_gnt     (if_gnt_raw),
    .mem_gnt    (mem_gnt_raw)
  );

  always_comb begin
    // No RAM traffic while in reset; stalls still mirror the requests.
    if_gnt    = if_gnt_raw && !rst;
    mem_gnt   = mem_gnt_raw && !rst;
    stall_if  = if_req && !if_gnt;
    stall_mem = mem_req && !mem_gnt;

    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    rd_owner_d = RD_NONE;
    if (if_gnt) begin
      ram_ce     = 1'b1;
      ram_addr   = if_addr;
      rd_owner_d = RD_IF;
    end else if (mem_gnt) begin
      ram_ce   = 1'b1;
      ram_we   = mem_we;
      ram_addr = mem_addr;
      if (mem_we) ram_wdata = mem_wdata;
      else        rd_owner_d = RD_MEM;
    end

    starve_d = (if_req && !if_gnt) ? starve_sat_inc(starve_q) : '0;

    // A read granted just before reset must not surface during reset.
    if_rvalid  = (rd_owner_q == RD_IF) && !rst;
    mem_rvalid = (rd_owner_q == RD_MEM) && !rst;
    if_rdata   = if_rvalid ? ram_rdata : DW'(EXE_NOP_OP);
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end

  // Grant -> return boundary: owner of next cycle's RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= RD_NONE;
      starve_q   <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
    end
  end

`ifdef MEM_ARB_STAT_EN
  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = (if_req && mem_req) ? sat16_inc(conflict_q) : conflict_q;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= '0;
    else     conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
